// File: rtl/led_sel_gen.sv
// Running-light index source for a 3-to-8 LED decoder: a prescaled 0..7 index with
// debounced run/pause and direction keys.
module led_sel_gen #(
    parameter int unsigned CNT_MAX = 24_999_999,
    parameter int unsigned DB_MAX  = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_run,
    input  logic key_dir,
    output logic sel1,
    output logic sel2,
    output logic sel3,
    output logic step_flag,
    output logic running,
    output logic dir
);

    localparam int unsigned CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned DW = (DB_MAX > 0) ? $clog2(DB_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_MAX);
    localparam logic [DW-1:0] DB_PRE   = DW'(DB_MAX - 1);

    typedef enum logic {StStop, StRun} state_e;

    logic [1:0] keys;
    logic [1:0] press;

    assign keys = {key_dir, key_run};

    for (genvar i = 0; i < 2; i++) begin : g_key
        logic          sync1_q;
        logic          sync2_q;
        logic          press_q;
        logic [DW-1:0] db_cnt_q;

        // Counter saturates at DB_LAST, so a held key yields a single press.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                sync1_q  <= 1'b1;
                sync2_q  <= 1'b1;
                press_q  <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                sync1_q <= keys[i];
                sync2_q <= sync1_q;
                press_q <= !sync2_q && (db_cnt_q == DB_PRE);
                if (sync2_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q < DB_LAST) begin
                    db_cnt_q <= db_cnt_q + DW'(1);
                end
            end
        end

        assign press[i] = press_q;
    end

    state_e        state_q;
    logic          dir_q;
    logic          step_flag_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= StRun;
            dir_q       <= 1'b0;
            step_flag_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
        end else begin
            step_flag_q <= 1'b0;
            if (state_q == StRun) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q       <= '0;
                    step_flag_q <= 1'b1;
                    idx_q       <= dir_q ? idx_q - 3'd1 : idx_q + 3'd1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            // Toggles land on the same edge as a step; the step still uses the old dir.
            if (press[0]) begin
                state_q <= (state_q == StRun) ? StStop : StRun;
            end
            if (press[1]) begin
                dir_q <= ~dir_q;
            end
        end
    end

    assign {sel3, sel2, sel1} = idx_q;
    assign step_flag          = step_flag_q;
    assign running            = (state_q == StRun);
    assign dir                = dir_q;

endmodule

// File: tb/tb_led_sel_gen.sv
// Directed self-checking bench for led_sel_gen with CNT_MAX=9, DB_MAX=4.
// Timing is tracked as t = rising edges since reset release; inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_led_sel_gen;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic key_run = 1'b1;
    logic key_dir = 1'b1;
    logic sel1, sel2, sel3, step_flag, running, dir;
    logic [2:0] sel;

    int errors = 0;
    int checks = 0;
    int t = 0;

    assign sel = {sel3, sel2, sel1};

    always #5 sys_clk = ~sys_clk;

    led_sel_gen #(
        .CNT_MAX(9),
        .DB_MAX (4)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_run  (key_run),
        .key_dir  (key_dir),
        .sel1     (sel1),
        .sel2     (sel2),
        .sel3     (sel3),
        .step_flag(step_flag),
        .running  (running),
        .dir      (dir)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
        t = t + 1;
    endtask

    task automatic run_to(input int n);
        while (t < n) tick();
    endtask

    // Assert between edges, release 3 ns after the next rising edge; t counts from there.
    task automatic apply_reset();
        key_run = 1'b1;
        key_dir = 1'b1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        t = 0;
    endtask

    task automatic test_reset();
        #3;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (sel !== 3'd0) begin
            errors++; $display("FAIL reset_sel got %0d want 0", sel);
        end
        checks++;
        if (step_flag !== 1'b0 || running !== 1'b1 || dir !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got flag=%b run=%b dir=%b want 0 1 0",
                     step_flag, running, dir);
        end
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        t = 0;
    endtask

    task automatic test_sequence();
        logic [2:0] exp_sel;
        apply_reset();
        for (int k = 1; k <= 80; k++) begin
            tick();
            exp_sel = 3'((k / 10) % 8);
            checks++;
            if (sel !== exp_sel || step_flag !== (k % 10 == 0)) begin
                errors++;
                $display("FAIL seq t=%0d got sel=%0d flag=%b want sel=%0d flag=%b",
                         k, sel, step_flag, exp_sel, (k % 10 == 0));
            end
        end
    endtask

    task automatic test_dir();
        apply_reset();
        run_to(22);
        key_dir = 1'b0;
        run_to(28);
        checks++;
        if (dir !== 1'b0) begin
            errors++; $display("FAIL dir_early got %b want 0", dir);
        end
        run_to(29);
        checks++;
        if (dir !== 1'b1) begin
            errors++; $display("FAIL dir_toggle got %b want 1", dir);
        end
        run_to(30);
        checks++;
        if (sel !== 3'd1 || step_flag !== 1'b1) begin
            errors++; $display("FAIL dir_step1 got sel=%0d flag=%b want 1 1", sel, step_flag);
        end
        run_to(34);
        key_dir = 1'b1;
        run_to(40);
        checks++;
        if (sel !== 3'd0) begin
            errors++; $display("FAIL dir_step2 got %0d want 0", sel);
        end
        run_to(50);
        checks++;
        if (sel !== 3'd7) begin
            errors++; $display("FAIL dir_wrap got %0d want 7", sel);
        end
        run_to(60);
        checks++;
        if (sel !== 3'd6 || step_flag !== 1'b1 || dir !== 1'b1) begin
            errors++;
            $display("FAIL dir_step4 got sel=%0d flag=%b dir=%b want 6 1 1", sel, step_flag, dir);
        end
    endtask

    task automatic test_run_pause();
        apply_reset();
        // Two short bounces, each below the debounce length.
        run_to(3);  key_run = 1'b0;
        run_to(6);  key_run = 1'b1;
        run_to(8);  key_run = 1'b0;
        run_to(11); key_run = 1'b1;
        run_to(20);
        checks++;
        if (running !== 1'b1 || sel !== 3'd2) begin
            errors++; $display("FAIL bounce got run=%b sel=%0d want 1 2", running, sel);
        end
        run_to(24); key_run = 1'b0;
        run_to(30);
        checks++;
        if (running !== 1'b1 || sel !== 3'd3 || step_flag !== 1'b1) begin
            errors++;
            $display("FAIL pre_stop got run=%b sel=%0d flag=%b want 1 3 1", running, sel, step_flag);
        end
        run_to(31);
        checks++;
        if (running !== 1'b0) begin
            errors++; $display("FAIL stop got run=%b want 0", running);
        end
        for (int k = 32; k <= 81; k++) begin
            if (k == 45) key_run = 1'b1;
            tick();
            checks++;
            if (running !== 1'b0 || sel !== 3'd3 || step_flag !== 1'b0) begin
                errors++;
                $display("FAIL frozen t=%0d got run=%b sel=%0d flag=%b want 0 3 0",
                         k, running, sel, step_flag);
            end
        end
        key_run = 1'b0;
        run_to(87);
        checks++;
        if (running !== 1'b0) begin
            errors++; $display("FAIL resume_early got %b want 0", running);
        end
        run_to(88);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL resume got %b want 1", running);
        end
        run_to(91); key_run = 1'b1;
        run_to(96);
        checks++;
        if (sel !== 3'd3 || step_flag !== 1'b0) begin
            errors++; $display("FAIL held_cnt_pre got sel=%0d flag=%b want 3 0", sel, step_flag);
        end
        run_to(97);
        checks++;
        if (sel !== 3'd4 || step_flag !== 1'b1) begin
            errors++; $display("FAIL held_cnt_step got sel=%0d flag=%b want 4 1", sel, step_flag);
        end
    endtask

    task automatic test_run_hold();
        apply_reset();
        run_to(2); key_run = 1'b0;
        run_to(8);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL hold_pre got %b want 1", running);
        end
        for (int k = 9; k <= 202; k++) begin
            run_to(k);
            checks++;
            if (running !== 1'b0) begin
                errors++; $display("FAIL hold t=%0d got run=%b want 0", k, running);
            end
        end
        key_run = 1'b1;
        run_to(210); key_run = 1'b0;
        run_to(216);
        checks++;
        if (running !== 1'b0 || sel !== 3'd0) begin
            errors++; $display("FAIL hold2_pre got run=%b sel=%0d want 0 0", running, sel);
        end
        run_to(217);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL hold2 got %b want 1", running);
        end
        run_to(218);
        checks++;
        if (sel !== 3'd1 || step_flag !== 1'b1) begin
            errors++; $display("FAIL hold2_step got sel=%0d flag=%b want 1 1", sel, step_flag);
        end
        run_to(225); key_run = 1'b1;
    endtask

    task automatic test_coincide();
        apply_reset();
        run_to(13); key_run = 1'b0;
        run_to(19);
        checks++;
        if (sel !== 3'd1 || running !== 1'b1 || step_flag !== 1'b0) begin
            errors++;
            $display("FAIL coin_pre got sel=%0d run=%b flag=%b want 1 1 0", sel, running, step_flag);
        end
        run_to(20);
        checks++;
        if (sel !== 3'd2 || running !== 1'b0 || step_flag !== 1'b1) begin
            errors++;
            $display("FAIL coin_edge got sel=%0d run=%b flag=%b want 2 0 1", sel, running, step_flag);
        end
        for (int k = 21; k <= 60; k++) begin
            if (k == 24) key_run = 1'b1;
            tick();
            checks++;
            if (sel !== 3'd2 || running !== 1'b0 || step_flag !== 1'b0) begin
                errors++;
                $display("FAIL coin_after t=%0d got sel=%0d run=%b flag=%b want 2 0 0",
                         k, sel, running, step_flag);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_sel;
        apply_reset();
        run_to(50);
        checks++;
        if (sel !== 3'd5) begin
            errors++; $display("FAIL mid_pre got %0d want 5", sel);
        end
        run_to(52); key_run = 1'b0;
        run_to(56);
        #3;
        sys_rst = 1'b1;
        key_run = 1'b1;
        #1;
        checks++;
        if (sel !== 3'd0 || running !== 1'b1 || dir !== 1'b0 || step_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got sel=%0d run=%b dir=%b flag=%b want 0 1 0 0",
                     sel, running, dir, step_flag);
        end
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        t = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            exp_sel = 3'((k / 10) % 8);
            checks++;
            if (sel !== exp_sel || step_flag !== (k % 10 == 0) || running !== 1'b1) begin
                errors++;
                $display("FAIL mid_restart t=%0d got sel=%0d flag=%b run=%b want %0d %b 1",
                         k, sel, step_flag, running, exp_sel, (k % 10 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_dir();
        test_run_pause();
        test_run_hold();
        test_coincide();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
